// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: hands a single shared SPI master to one of two requesters.
// Ownership is level-held on req_i, released through DRAIN (wait for the shifter)
// and GUARD (idle gap so SSn deasserts). Simultaneous requests alternate.
// Optional feature: define SPI_ARB_TIMEOUT_EN to bound each ownership to
// HOLD_MAX grant cycles, with sticky timeout flags and per-requester masking.
module spi_bus_arbiter #(
  parameter int HOLD_MAX  = 1023,
  parameter int GUARD_CYC = 2
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic [1:0] req_i,
  input  logic       spi_busy_i,
  output logic [1:0] gnt_o,
  output logic       sel_o,
  output logic       busy_o,
  output logic [1:0] timeout_o,
  input  logic       tmo_clr_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GUARD = 2'd3
  } state_t;

  localparam logic       GUARD_EN   = (GUARD_CYC > 0);
  localparam logic [3:0] GUARD_LAST = (GUARD_CYC > 0) ? 4'(GUARD_CYC - 1) : 4'd0;

  state_t     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic       sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       last_q, last_d;
  logic [3:0] guard_cnt_q, guard_cnt_d;
  logic [1:0] elig_s;
  logic       win_s;
  logic       grant_now_s;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_MAX - 1);
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic [1:0]  mask_q, mask_d;
  logic [1:0]  tmo_q, tmo_d;
`else
  logic unused_tmo_clr_s;
  assign unused_tmo_clr_s = tmo_clr_i;
`endif

  // Round-robin pick: on a tie the requester not served last wins.
  function automatic logic pick_winner(input logic [1:0] elig, input logic last);
    logic win;
    if (elig == 2'b11) begin
      win = ~last;
    end else begin
      win = elig[1];
    end
    return win;
  endfunction

  // Next-state, grant, select, counter and flag computation.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    last_d      = last_q;
    guard_cnt_d = guard_cnt_q;
    grant_now_s = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
    hold_cnt_d  = hold_cnt_q;
    // a mask lifts once its requester has let go of req_i
    mask_d      = mask_q & req_i;
    tmo_d       = tmo_clr_i ? 2'b00 : tmo_q;
    elig_s      = req_i & ~mask_q;
`else
    elig_s      = req_i;
`endif
    win_s       = pick_winner(elig_s, last_q);

    case (state_q)
      ST_IDLE: begin
        if (elig_s != 2'b00) begin
          grant_now_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        // a voluntary drop wins over a simultaneous hold-limit hit
        if (!req_i[sel_q]) begin
          state_d = ST_DRAIN;
          gnt_d   = 2'b00;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (hold_cnt_q == HOLD_LAST) begin
          state_d       = ST_DRAIN;
          gnt_d         = 2'b00;
          tmo_d[sel_q]  = 1'b1;
          mask_d[sel_q] = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 16'd1;
        end
`else
        else begin
          state_d = ST_GRANT;
        end
`endif
      end
      ST_DRAIN: begin
        if (spi_busy_i) begin
          state_d = ST_DRAIN;
        end else if (GUARD_EN) begin
          state_d     = ST_GUARD;
          guard_cnt_d = 4'd0;
        end else if (elig_s != 2'b00) begin
          // no guard gap: arbitrate here so DRAIN is the only zero-grant cycle
          grant_now_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GUARD: begin
        if (guard_cnt_q == GUARD_LAST) begin
          state_d = ST_IDLE;
        end else begin
          guard_cnt_d = guard_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
    endcase

    if (grant_now_s) begin
      state_d = ST_GRANT;
      gnt_d   = win_s ? 2'b10 : 2'b01;
      sel_d   = win_s;
      last_d  = win_s;
`ifdef SPI_ARB_TIMEOUT_EN
      hold_cnt_d = 16'd0;
`endif
    end else begin
      last_d = last_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset removes the grant immediately.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 2'b00;
      sel_q       <= 1'b0;
      busy_q      <= 1'b0;
      last_q      <= 1'b1;
      guard_cnt_q <= 4'd0;
`ifdef SPI_ARB_TIMEOUT_EN
      hold_cnt_q  <= 16'd0;
      mask_q      <= 2'b00;
      tmo_q       <= 2'b00;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      last_q      <= last_d;
      guard_cnt_q <= guard_cnt_d;
`ifdef SPI_ARB_TIMEOUT_EN
      hold_cnt_q  <= hold_cnt_d;
      mask_q      <= mask_d;
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign gnt_o  = gnt_q;
  assign sel_o  = sel_q;
  assign busy_o = busy_q;
`ifdef SPI_ARB_TIMEOUT_EN
  assign timeout_o = tmo_q;
`else
  assign timeout_o = 2'b00;
`endif

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter. Each expected output change
// ({busy, timeout, sel, gnt} and the cycle it appears in) is queued by the
// stimulus; a monitor pops and compares on every observed change.
// Instance dut_a: HOLD_MAX=8, GUARD_CYC=2. Instance dut_b: GUARD_CYC=0.
module tb_spi_bus_arbiter;

  typedef struct {
    int         cyc;
    logic [5:0] vec;
  } exp_t;

  logic       HCLK       = 1'b0;
  logic       HRESETn    = 1'b1;
  logic [1:0] req        = 2'b00;
  logic       spi_busy   = 1'b0;
  logic       tmo_clr    = 1'b0;
  logic [1:0] req_g      = 2'b00;
  logic       spi_busy_g = 1'b0;
  logic       tmo_clr_g  = 1'b0;

  logic [1:0] gnt_a, tmo_a, gnt_b, tmo_b;
  logic       sel_a, busy_a, sel_b, busy_b;

  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  logic done  = 1'b0;
  exp_t exp_a[$];
  exp_t exp_b[$];

  spi_bus_arbiter #(.HOLD_MAX(8), .GUARD_CYC(2)) dut_a (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_i(req), .spi_busy_i(spi_busy),
    .gnt_o(gnt_a), .sel_o(sel_a), .busy_o(busy_a), .timeout_o(tmo_a),
    .tmo_clr_i(tmo_clr)
  );

  spi_bus_arbiter #(.HOLD_MAX(1023), .GUARD_CYC(0)) dut_b (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_i(req_g), .spi_busy_i(spi_busy_g),
    .gnt_o(gnt_b), .sel_o(sel_b), .busy_o(busy_b), .timeout_o(tmo_b),
    .tmo_clr_i(tmo_clr_g)
  );

  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) cyc <= cyc + 1;

  function automatic logic [5:0] mk(input logic [1:0] g, input logic s,
                                    input logic b, input logic [1:0] t);
    return {b, t, s, g};
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic expect_a(input int d, input logic [5:0] v);
    exp_t e;
    e.cyc = cyc + d;
    e.vec = v;
    exp_a.push_back(e);
  endtask

  task automatic expect_b(input int d, input logic [5:0] v);
    exp_t e;
    e.cyc = cyc + d;
    e.vec = v;
    exp_b.push_back(e);
  endtask

  task automatic pulse_reset();
    HRESETn = 1'b0;
    #1;
    total++;
    if ({busy_a, tmo_a, sel_a, gnt_a} !== 6'd0) begin
      bad++;
      $display("FAIL reset_async got=%b want=%b", {busy_a, tmo_a, sel_a, gnt_a}, 6'd0);
    end
    step(2);
    HRESETn = 1'b1;
  endtask

  initial begin
    fork
      begin : monitor
        logic [5:0] prev_a;
        logic [5:0] prev_b;
        logic [5:0] now_a;
        logic [5:0] now_b;
        exp_t       e;
        prev_a = 6'd0;
        prev_b = 6'd0;
        while (!done) begin
          @(negedge HCLK);
          now_a = {busy_a, tmo_a, sel_a, gnt_a};
          now_b = {busy_b, tmo_b, sel_b, gnt_b};
          if (now_a !== prev_a) begin
            total++;
            if (exp_a.size() == 0) begin
              bad++;
              $display("FAIL dut_a_unexpected cyc=%0d got=%b", cyc, now_a);
            end else begin
              e = exp_a.pop_front();
              if (e.cyc != cyc || e.vec !== now_a) begin
                bad++;
                $display("FAIL dut_a_event got cyc=%0d vec=%b want cyc=%0d vec=%b",
                         cyc, now_a, e.cyc, e.vec);
              end
            end
            prev_a = now_a;
          end
          if (now_b !== prev_b) begin
            total++;
            if (exp_b.size() == 0) begin
              bad++;
              $display("FAIL dut_b_unexpected cyc=%0d got=%b", cyc, now_b);
            end else begin
              e = exp_b.pop_front();
              if (e.cyc != cyc || e.vec !== now_b) begin
                bad++;
                $display("FAIL dut_b_event got cyc=%0d vec=%b want cyc=%0d vec=%b",
                         cyc, now_b, e.cyc, e.vec);
              end
            end
            prev_b = now_b;
          end
        end
      end
      begin : stimulus
        step(1);
        pulse_reset();
        step(1);

        // single requester, drop with shifter idle, two guard cycles
        req = 2'b01;
        expect_a(1, mk(2'b01, 1'b0, 1'b1, 2'b00));
        expect_a(6, mk(2'b00, 1'b0, 1'b1, 2'b00));
        expect_a(9, mk(2'b00, 1'b0, 1'b0, 2'b00));
        step(5); req = 2'b00;
        step(6);

        // tie from reset goes to requester 0, next tie to requester 1
        req = 2'b11;
        pulse_reset();
        expect_a(1,  mk(2'b01, 1'b0, 1'b1, 2'b00));
        expect_a(3,  mk(2'b00, 1'b0, 1'b1, 2'b00));
        expect_a(6,  mk(2'b00, 1'b0, 1'b0, 2'b00));
        expect_a(7,  mk(2'b10, 1'b1, 1'b1, 2'b00));
        expect_a(9,  mk(2'b00, 1'b1, 1'b1, 2'b00));
        expect_a(12, mk(2'b00, 1'b1, 1'b0, 2'b00));
        step(2); req = 2'b00;
        step(4); req = 2'b11;
        step(2); req = 2'b00;
        step(5);

        // drop while the shifter is busy; requester 1 waits for drain + guard
        req = 2'b01;
        expect_a(1,  mk(2'b01, 1'b0, 1'b1, 2'b00));
        expect_a(4,  mk(2'b00, 1'b0, 1'b1, 2'b00));
        expect_a(13, mk(2'b00, 1'b0, 1'b0, 2'b00));
        expect_a(14, mk(2'b10, 1'b1, 1'b1, 2'b00));
        expect_a(16, mk(2'b00, 1'b1, 1'b1, 2'b00));
        expect_a(19, mk(2'b00, 1'b1, 1'b0, 2'b00));
        step(1); spi_busy = 1'b1;
        step(1); req = 2'b11;
        step(1); req = 2'b10;
        step(7); spi_busy = 1'b0;
        step(5); req = 2'b00;
        step(5);

`ifdef SPI_ARB_TIMEOUT_EN
        // hold limit: forced release, flag set despite same-cycle clear, mask
        req = 2'b01;
        expect_a(1,  mk(2'b01, 1'b0, 1'b1, 2'b00));
        expect_a(9,  mk(2'b00, 1'b0, 1'b1, 2'b01));
        expect_a(12, mk(2'b00, 1'b0, 1'b0, 2'b01));
        expect_a(17, mk(2'b01, 1'b0, 1'b1, 2'b01));
        expect_a(19, mk(2'b00, 1'b0, 1'b1, 2'b01));
        expect_a(22, mk(2'b00, 1'b0, 1'b0, 2'b01));
        expect_a(24, mk(2'b00, 1'b0, 1'b0, 2'b00));
        step(8); tmo_clr = 1'b1;
        step(1); tmo_clr = 1'b0;
        step(6); req = 2'b00;
        step(1); req = 2'b01;
        step(2); req = 2'b00;
        step(5); tmo_clr = 1'b1;
        step(1); tmo_clr = 1'b0;
        step(2);
`else
        // ownership unbounded, timeout flags stay low, clear ignored
        req = 2'b01;
        expect_a(1,  mk(2'b01, 1'b0, 1'b1, 2'b00));
        expect_a(14, mk(2'b00, 1'b0, 1'b1, 2'b00));
        expect_a(17, mk(2'b00, 1'b0, 1'b0, 2'b00));
        step(8); tmo_clr = 1'b1;
        step(1); tmo_clr = 1'b0;
        step(4); req = 2'b00;
        step(5);
`endif

        // reset in the middle of an ownership
        req = 2'b10;
        expect_a(1, mk(2'b10, 1'b1, 1'b1, 2'b00));
        expect_a(3, mk(2'b00, 1'b0, 1'b0, 2'b00));
        step(3);
        pulse_reset();
        req = 2'b00;
        step(2);

        // zero guard: only the DRAIN cycle separates back-to-back owners
        req_g = 2'b11;
        expect_b(1, mk(2'b01, 1'b0, 1'b1, 2'b00));
        expect_b(4, mk(2'b00, 1'b0, 1'b1, 2'b00));
        expect_b(5, mk(2'b10, 1'b1, 1'b1, 2'b00));
        expect_b(7, mk(2'b00, 1'b1, 1'b1, 2'b00));
        expect_b(8, mk(2'b00, 1'b1, 1'b0, 2'b00));
        step(3); req_g = 2'b10;
        step(3); req_g = 2'b00;
        step(4);
        done = 1'b1;
      end
    join

    total++;
    if (exp_a.size() != 0) begin
      bad++;
      $display("FAIL dut_a_missing got=%0d pending want=0", exp_a.size());
    end
    total++;
    if (exp_b.size() != 0) begin
      bad++;
      $display("FAIL dut_b_missing got=%0d pending want=0", exp_b.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
